// File: rtl/mem_arbiter_if.sv
// Shared data-memory bus: two requester ports (A = CPU, B = loader/debug) plus the memory side.
// Optional b_lock signal exists only when MEM_ARB_LOCK_EN is defined.
interface mem_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [14:0] a_addr;
    logic [15:0] a_wdata;
    logic        a_ack;
    logic [15:0] a_rdata;

    logic        b_req;
    logic        b_we;
    logic [14:0] b_addr;
    logic [15:0] b_wdata;
    logic        b_ack;
    logic [15:0] b_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic        b_lock;
`endif

    logic [15:0] mem_in;
    logic [14:0] mem_address;
    logic        mem_load;
    logic [15:0] mem_out;
    logic        busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
`ifdef MEM_ARB_LOCK_EN
        input  b_lock,
`endif
        output mem_in, mem_address, mem_load,
        input  mem_out,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
`ifdef MEM_ARB_LOCK_EN
        output b_lock,
`endif
        input  mem_in, mem_address, mem_load,
        output mem_out,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single data-memory port: IDLE -> ACCESS -> RESP, one transaction per grant.
// Optional MEM_ARB_LOCK_EN adds b_lock so port B can hold the memory for back-to-back bursts.
module mem_arbiter (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q;
    logic        owner_q;       // 0 = port A, 1 = port B
    logic        last_q;
    logic        owner_d;
    logic        a_ack_q, b_ack_q;
    logic [15:0] a_rdata_q, b_rdata_q;
    logic        busy_q;
`ifdef MEM_ARB_LOCK_EN
    logic        lock_q;
`endif

    logic        own_we;
    logic [14:0] own_addr;
    logic [15:0] own_wdata;

    assign own_we    = owner_q ? bus.b_we    : bus.a_we;
    assign own_addr  = owner_q ? bus.b_addr  : bus.a_addr;
    assign own_wdata = owner_q ? bus.b_wdata : bus.a_wdata;

    always_comb begin
        owner_d = 1'b0;
        if (bus.a_req && bus.b_req)
            owner_d = ~last_q;
        else
            owner_d = bus.b_req;
`ifdef MEM_ARB_LOCK_EN
        if (lock_q && bus.b_req)
            owner_d = 1'b1;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= 16'h0000;
            b_rdata_q <= 16'h0000;
            busy_q    <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.a_req || bus.b_req) begin
                        owner_q <= owner_d;
                        last_q  <= owner_d;
                        state_q <= ACCESS;
                        busy_q  <= 1'b1;
`ifdef MEM_ARB_LOCK_EN
                        lock_q  <= 1'b0;
`endif
                    end
                end
                ACCESS: begin
                    // Writes leave the owner's read-data register untouched.
                    if (owner_q) begin
                        b_ack_q <= 1'b1;
                        if (!own_we) b_rdata_q <= bus.mem_out;
                    end else begin
                        a_ack_q <= 1'b1;
                        if (!own_we) a_rdata_q <= bus.mem_out;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef MEM_ARB_LOCK_EN
                    lock_q  <= owner_q & bus.b_lock;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset gates the write strobe so an interrupted ACCESS never commits.
    assign bus.mem_load    = (state_q == ACCESS) & own_we & ~reset;
    assign bus.mem_address = own_addr;
    assign bus.mem_in      = own_wdata;
    assign bus.a_ack       = a_ack_q;
    assign bus.b_ack       = b_ack_q;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed traffic with a per-port expected-ack scoreboard and a memory model.
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_arbiter_if bus();
    mem_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

    logic [15:0] mem [0:32767];
    assign bus.mem_out = mem[bus.mem_address];
    always @(posedge clock) if (bus.mem_load) mem[bus.mem_address] <= bus.mem_in;

    typedef struct { bit chk; logic [15:0] rd; } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    logic [15:0] ord_bits = '0;
    int ord_n = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    initial forever begin
        @(negedge clock);
        if (bus.mem_load === 1'b1) wr_cnt++;
    end

    // Monitor: every ack pops the matching port queue and checks read data.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (bus.a_ack === 1'b1) begin
            ord_bits = {ord_bits[14:0], 1'b0}; ord_n++;
            if (qa.size() == 0) check("a_ack_unexpected", 1, 0);
            else begin
                e = qa.pop_front();
                if (e.chk) check("a_rdata", bus.a_rdata, e.rd);
            end
        end
        if (bus.b_ack === 1'b1) begin
            ord_bits = {ord_bits[14:0], 1'b1}; ord_n++;
            if (qb.size() == 0) check("b_ack_unexpected", 1, 0);
            else begin
                e = qb.pop_front();
                if (e.chk) check("b_rdata", bus.b_rdata, e.rd);
            end
        end
    end

    // Issue one transaction at posedge+1; req stays high on return, caller drops it.
    task automatic txn(input bit port, input bit we, input logic [14:0] addr,
                       input logic [15:0] wd, input bit chk, input logic [15:0] rd,
                       output int lat);
        exp_t e;
        logic ack;
        e.chk = chk; e.rd = rd;
        if (port) begin
            qb.push_back(e);
            bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd; bus.b_req = 1'b1;
        end else begin
            qa.push_back(e);
            bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd; bus.a_req = 1'b1;
        end
        lat = 0;
        ack = 1'b0;
        while (!ack && lat < 20) begin
            @(negedge clock);
            lat++;
            ack = port ? bus.b_ack : bus.a_ack;
        end
        check(port ? "b_ack_seen" : "a_ack_seen", ack, 1);
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    int l1, l2, l3, l4, wp;

    initial begin
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        bus.b_lock = 1'b0;
`endif
        mem[15'h0010] = 16'h0A0A;
        mem[15'h0020] = 16'h5A5A;
        do_reset();

        @(negedge clock);
        check("rst_a_ack", bus.a_ack, 0);
        check("rst_b_ack", bus.b_ack, 0);
        check("rst_a_rdata", bus.a_rdata, 0);
        check("rst_b_rdata", bus.b_rdata, 0);
        check("rst_mem_load", bus.mem_load, 0);
        check("rst_busy", bus.busy, 0);

        // A write with cycle-exact checks
        @(posedge clock); #1;
        qa.push_back('{chk: 1'b0, rd: 16'h0000});
        bus.a_we = 1; bus.a_addr = 15'h0005; bus.a_wdata = 16'hBEEF; bus.a_req = 1;
        @(negedge clock);
        check("c1_mem_load", bus.mem_load, 0);
        check("c1_busy", bus.busy, 0);
        @(negedge clock);
        check("c2_mem_load", bus.mem_load, 1);
        check("c2_mem_address", bus.mem_address, 15'h0005);
        check("c2_mem_in", bus.mem_in, 16'hBEEF);
        check("c2_busy", bus.busy, 1);
        check("c2_a_ack", bus.a_ack, 0);
        @(negedge clock);
        check("c3_a_ack", bus.a_ack, 1);
        check("c3_mem_load", bus.mem_load, 0);
        check("c3_busy", bus.busy, 1);
        @(posedge clock); #1 bus.a_req = 0;
        @(negedge clock);
        check("c4_busy", bus.busy, 0);
        check("c4_a_ack", bus.a_ack, 0);

        // A read back
        @(posedge clock); #1;
        wp = wr_cnt;
        txn(0, 0, 15'h0005, 16'h0000, 1, 16'hBEEF, l1);
        bus.a_req = 0;
        check("rd_latency", l1, 3);
        check("rd_no_write", wr_cnt, wp);

        // LED register write through port B
        @(posedge clock); #1;
        wp = wr_cnt;
        txn(1, 1, 15'h4000, 16'h00FF, 0, 16'h0000, l1);
        bus.b_req = 0;
        check("led_latency", l1, 3);
        check("led_write_cnt", wr_cnt, wp + 1);
        check("led_mem", mem[15'h4000], 16'h00FF);
        check("a_rdata_held", bus.a_rdata, 16'hBEEF);

        // Simultaneous requests from reset
        do_reset();
        ord_bits = '0; ord_n = 0;
        @(posedge clock); #1;
        fork
            begin
                txn(0, 0, 15'h0010, 16'h0000, 1, 16'h0A0A, l1);
                txn(0, 0, 15'h0010, 16'h0000, 1, 16'h1234, l2);
                bus.a_req = 0;
            end
            begin
                txn(1, 1, 15'h0010, 16'h1234, 0, 16'h0000, l3);
                txn(1, 1, 15'h0010, 16'h1234, 0, 16'h0000, l4);
                bus.b_req = 0;
            end
        join
        check("rr_count", ord_n, 4);
        check("rr_order", ord_bits[3:0], 4'b0101);
        check("rr_lat_a1", l1, 3);
        check("rr_lat_b1", l3, 6);
        check("rr_lat_a2", l2, 6);
        check("rr_lat_b2", l4, 6);

        // Reset during ACCESS of an A write
        @(posedge clock); #1;
        wp = wr_cnt;
        bus.a_we = 1; bus.a_addr = 15'h0020; bus.a_wdata = 16'hDEAD; bus.a_req = 1;
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("rstacc_mem_load", bus.mem_load, 0);
        @(posedge clock); #1;
        reset = 1'b0; bus.a_req = 0;
        repeat (4) @(negedge clock);
        check("rstacc_no_write", wr_cnt, wp);
        check("rstacc_busy", bus.busy, 0);
        @(posedge clock); #1;
        txn(0, 0, 15'h0020, 16'h0000, 1, 16'h5A5A, l1);
        bus.a_req = 0;

`ifdef MEM_ARB_LOCK_EN
        // Locked burst: B,B,B then A
        do_reset();
        ord_bits = '0; ord_n = 0;
        @(posedge clock); #1;
        fork
            begin
                bus.b_lock = 1'b1;
                txn(1, 1, 15'h0030, 16'h0001, 0, 16'h0000, l1);
                txn(1, 1, 15'h0031, 16'h0002, 0, 16'h0000, l1);
                txn(1, 1, 15'h0032, 16'h0003, 0, 16'h0000, l1);
                bus.b_req = 0; bus.b_lock = 1'b0;
            end
            begin
                @(posedge clock); #1;
                txn(0, 0, 15'h0030, 16'h0000, 1, 16'h0001, l2);
                bus.a_req = 0;
            end
        join
        check("lock_count", ord_n, 4);
        check("lock_order", ord_bits[3:0], 4'b1110);

        // Unlocked: B,A,B,A
        ord_bits = '0; ord_n = 0;
        @(posedge clock); #1;
        fork
            begin
                txn(1, 1, 15'h0040, 16'h0011, 0, 16'h0000, l1);
                txn(1, 1, 15'h0041, 16'h0022, 0, 16'h0000, l1);
                bus.b_req = 0;
            end
            begin
                @(posedge clock); #1;
                txn(0, 0, 15'h0040, 16'h0000, 1, 16'h0011, l2);
                txn(0, 0, 15'h0041, 16'h0000, 1, 16'h0022, l2);
                bus.a_req = 0;
            end
        join
        check("unlock_count", ord_n, 4);
        check("unlock_order", ord_bits[3:0], 4'b1010);
`endif

        repeat (3) @(negedge clock);
        check("qa_empty", qa.size(), 0);
        check("qb_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port (16-bit data, 15-bit address, load) between two requesters.
  - Port A: the CPU data side.
  - Port B: a loader/debug master, e.g. a UART program loader or host peek/poke.
- Round-robin arbitration, one transaction per grant, req/ack handshake, registered read data.
- Sits directly in front of the memory block; address bit 14 still selects the LED register downstream, so both ports can reach it.

Parameters:
- none (widths fixed by the memory map: data 16, address 15)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- a_req  in  1  port A request; held with a_we/a_addr/a_wdata stable until a_ack
- a_we  in  1  port A write enable (1 = write, 0 = read)
- a_addr  in  15  port A word address
- a_wdata  in  16  port A write data
- a_ack  out  1  one-cycle pulse: port A transaction complete
- a_rdata  out  16  port A read data, valid while a_ack=1, held until next A read
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
- mem_in  out  16  to memory data input
- mem_address  out  15  to memory address
- mem_load  out  1  to memory load
- mem_out  in  16  from memory output (combinational read of mem_address)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state=IDLE, owner=A, last_grant=B (so A wins the first tie), a_ack=b_ack=0, a_rdata=b_rdata=0, mem_load=0, busy=0.
- State machine:
  - IDLE: if no request, stay in IDLE.
    - Only one of a_req/b_req high: owner <= that port.
    - Both high: owner <= the port that is not last_grant.
    - On any grant: last_grant <= owner, state <= ACCESS.
  - ACCESS (exactly 1 cycle):
    - mem_address, mem_in driven from the owner's addr/wdata.
    - mem_load = owner's we & ~reset.
    - At the edge: the write commits in memory; owner's rdata <= mem_out (reads only, writes leave rdata unchanged); owner's ack <= 1; state <= RESP.
  - RESP (1 cycle): owner's ack=1; state <= IDLE; ack clears at that edge.
- mem_address/mem_in outside ACCESS: follow the owner port (don't-care to memory); mem_load is 0 in every state except ACCESS.
- Latency: req first sampled at edge k -> ACCESS during cycle k+1 -> ack high during cycle k+2. Throughput is 1 transaction per 3 cycles.
- Handshake:
  - Requester may change or drop req at the edge ending its ack cycle.
  - If req is still high in IDLE after ack, it is a new transaction and is re-arbitrated.
  - Signals changing while req=1 before ack: undefined result, not checked.
- Fairness: with both ports requesting continuously, grants alternate A, B, A, B; neither port waits more than one other transaction (max 6 cycles from req to ack).
- req dropped by the non-owner while waiting: no effect, no ack.
- req dropped by the owner during ACCESS/RESP: transaction still completes, ack still pulses.
- Reset mid-transaction:
  - reset=1 during ACCESS forces mem_load=0, so no write occurs.
  - All registers return to reset values at that edge; no ack is issued.
- Address bit 14 is passed through unmodified; LED register accesses take identical timing.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - Adds input b_lock (1 bit).
  - If b_lock=1 during a B RESP cycle and b_req=1 in the following IDLE, B is granted again regardless of a_req; gives a burst loader exclusive back-to-back access.
  - A is blocked while lock holds; round-robin resumes when b_lock=0 in RESP.
- Not defined: no b_lock port; pure round-robin as above.

Test Plan:
- Reset then A write: a_req=1, a_we=1, a_addr=0x0005, a_wdata=0xBEEF at edge 1 -> mem_load=1 with mem_address=0x0005, mem_in=0xBEEF in cycle 2 only; a_ack=1 in cycle 3; busy=1 in cycles 2-3.
- A read back: a_addr=0x0005, a_we=0 -> a_ack in cycle 3, a_rdata=0xBEEF; b_ack stays 0; mem_load stays 0 throughout.
- Simultaneous requests: both held continuously from reset, A reads 0x0010, B writes 0x1234 to 0x0010 -> grant order A, B, A, B; first a_rdata = old value, second a_rdata=0x1234; each ack within 6 cycles of req.
- LED path: B writes 0x00FF to address 0x4000 -> mem_address=0x4000, mem_load=1 for one cycle; b_ack 2 cycles after sample.
- Reset mid-ACCESS: assert reset during the ACCESS cycle of an A write of 0xDEAD to 0x0020 -> mem_load=0 that cycle; no a_ack; a later read of 0x0020 returns the pre-reset value.
- With MEM_ARB_LOCK_EN: b_lock=1, B issues 3 writes while a_req held -> B,B,B then A; with b_lock=0, the same traffic yields B,A,B,A.
